// File: rtl/button_event.sv
// button_event: turns a debounced button level into single-cycle event pulses.
//
// The input comes from a debouncer running on its own divided clock, so it is
// resynchronised (two flops) before any edge detection. Events are registered
// and each lasts exactly one clk cycle.
//
// Optional feature: define BUTTON_EVENT_DCLICK_EN to enable double-click detection.
// Without it, the WAIT_DBL state is never entered and dbl_click stays 0.
//
// Parameters:
//   CNT_W        width of the hold/interval counter
//   LONG_TICKS   clk cycles from press pulse to long_press pulse (2..2^CNT_W-1)
//   REPEAT_TICKS clk cycles between repeat pulses (1..2^CNT_W-1)
//   DCLICK_TICKS double-click window in clk cycles (macro build only)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   in           debounced button level, asynchronous to clk
//   held         synchronised button level
//   press        pulse on rising edge of the synchronised level
//   release_evt  pulse on falling edge of the synchronised level
//   short_click  pulse on a release that comes before long_press
//   long_press   pulse after LONG_TICKS of continuous hold
//   repeat_evt   pulse every REPEAT_TICKS after long_press while still held
//   dbl_click    pulse on the second press of a double click
//
// "release" and "repeat" are SystemVerilog keywords, hence the _evt suffix.

module button_event #(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned LONG_TICKS   = 12000000,
    parameter int unsigned REPEAT_TICKS = 3000000,
    parameter int unsigned DCLICK_TICKS = 6000000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic held,
    output logic press,
    output logic release_evt,
    output logic short_click,
    output logic long_press,
    output logic repeat_evt,
    output logic dbl_click
);

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_TICKS - 1);
    localparam logic [CNT_W-1:0] DclickLim  = CNT_W'(DCLICK_TICKS);

    typedef enum logic [1:0] {StIdle, StPressed, StLong, StWaitDbl} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q, prev_q;
    // Set while the current press is the second press of a double click.
    logic             second_q, second_d;

    logic press_q, press_d;
    logic release_q, release_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic dbl_q, dbl_d;

    logic rise, fall, long_hit, repeat_hit, dbl_end, dbl_ok;

    assign rise       = s2_q & ~prev_q;
    assign fall       = ~s2_q & prev_q;
    assign long_hit   = (cnt_q == LongLast);
    assign repeat_hit = (cnt_q == RepeatLast);
    assign dbl_end    = (cnt_q == DclickLast);
    assign dbl_ok     = rise && (cnt_q < DclickLim);

    // State register, synchroniser and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            prev_q    <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            second_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            dbl_q     <= 1'b0;
        end else begin
            s1_q      <= in;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            second_q  <= second_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            dbl_q     <= dbl_d;
        end
    end

    // Next-state and counter. A fall always takes priority over a threshold.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        second_d = second_q;
        unique case (state_q)
            StIdle: begin
                cnt_d    = '0;
                second_d = 1'b0;
                if (rise) state_d = StPressed;
            end
            StPressed: begin
                if (fall) begin
                    cnt_d    = '0;
                    second_d = 1'b0;
`ifdef BUTTON_EVENT_DCLICK_EN
                    state_d  = second_q ? StIdle : StWaitDbl;
`else
                    state_d  = StIdle;
`endif
                end else if (long_hit) begin
                    cnt_d   = '0;
                    state_d = StLong;
                end
            end
            StLong: begin
                if (fall) begin
                    cnt_d    = '0;
                    second_d = 1'b0;
                    state_d  = StIdle;
                end else if (repeat_hit) begin
                    cnt_d = '0;
                end
            end
            StWaitDbl: begin
                // Rise is checked first so a rise on the timeout cycle still counts.
                if (dbl_ok) begin
                    cnt_d    = '0;
                    second_d = 1'b1;
                    state_d  = StPressed;
                end else if (dbl_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Event decode, registered on the next edge.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        dbl_d     = 1'b0;
        unique case (state_q)
            StIdle: press_d = rise;
            StPressed: begin
                if (fall) begin
                    release_d = 1'b1;
                    short_d   = ~second_q;
                end else begin
                    long_d = long_hit;
                end
            end
            StLong: begin
                if (fall) release_d = 1'b1;
                else      repeat_d  = repeat_hit;
            end
            StWaitDbl: begin
                if (dbl_ok) begin
                    press_d = 1'b1;
`ifdef BUTTON_EVENT_DCLICK_EN
                    dbl_d   = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    assign held        = s2_q;
    assign press       = press_q;
    assign release_evt = release_q;
    assign short_click = short_q;
    assign long_press  = long_q;
    assign repeat_evt  = repeat_q;
    assign dbl_click   = dbl_q;

endmodule
